bt_packet_deframer: RTL and testbench

- Sits directly downstream of the Bluetooth UART byte receiver. Consumes its byte output and its done flag (a level, not a pulse).
- Hunts for a sync byte, then collects a type byte, a length byte, the payload and an XOR checksum.
- Buffers the payload and, once the checksum passes, streams it to the drawing/chat logic over valid/ready with a last marker.
- Detects errors and counts dropped bytes.

---
 rtl/bt_pkt_pkg.sv | 22 ++
 rtl/bt_packet_deframer_if.sv | 24 ++
 rtl/bt_pkt_buffer.sv | 25 ++
 rtl/bt_packet_deframer.sv | 174 +++++++++++++++++
 tb/tb_bt_packet_deframer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bt_pkt_pkg.sv
// Shared definitions for the Bluetooth packet deframer.
// Holds the FSM state encoding, the default sync marker and the checksum seed helper.
// Imported by the deframer top and its interface users.
package bt_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        TYPE    = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CHECK   = 3'd4,
        DRAIN   = 3'd5
    } bt_state_e;

    // Checksum value once the type and length bytes have been absorbed.
    function automatic logic [7:0] pkt_xor(input logic [7:0] typ, input logic [7:0] len);
        return typ ^ len;
    endfunction

endpackage

// File: rtl/bt_packet_deframer_if.sv
// Byte-in / payload-out bundle of the Bluetooth packet deframer.
// slave: the deframer side (consumes UART bytes, drives the payload stream and status).
// master: the environment side (UART receiver + drawing/chat consumer).
interface bt_packet_deframer_if;
    logic [7:0] byte_in;
    logic       byte_done;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] out_type;
    logic       pkt_err;
    logic [7:0] drop_count;

    modport slave (
        input  byte_in, byte_done, out_ready,
        output out_data, out_valid, out_last, out_type, pkt_err, drop_count
    );

    modport master (
        output byte_in, byte_done, out_ready,
        input  out_data, out_valid, out_last, out_type, pkt_err, drop_count
    );
endinterface

// File: rtl/bt_pkt_buffer.sv
// Payload store: DEPTH x 8 register array, one synchronous write port, combinational read.
// Ports: clk, we/waddr/wdata (write), raddr -> rdata (read, same cycle).
// Contents are not reset; the deframer only reads entries it has written for the current packet.
module bt_pkt_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bt_packet_deframer.sv
// Bluetooth packet deframer: sync/type/len/payload/xor-checksum parser feeding a valid/ready payload stream.
// Ports: clk, rst_in (async, active-high), bus (byte_in/byte_done in; out_* stream, pkt_err, drop_count out).
// Latency: a byte is absorbed on the edge its done-rise is seen; the drain starts the cycle after a good checksum.
// Backpressure: out_* hold while out_ready is low; bytes arriving during the drain are dropped and counted.
module bt_packet_deframer
    import bt_pkt_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 200000
) (
    input  logic                 clk,
    input  logic                 rst_in,
    bt_packet_deframer_if.slave  bus
);
    localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       MAX_LEN8   = 8'(MAX_LEN);

    localparam logic [2:0] S_HUNT    = HUNT;
    localparam logic [2:0] S_TYPE    = TYPE;
    localparam logic [2:0] S_LEN     = LEN;
    localparam logic [2:0] S_PAYLOAD = PAYLOAD;
    localparam logic [2:0] S_CHECK   = CHECK;
    localparam logic [2:0] S_DRAIN   = DRAIN;

    logic [2:0]       state;
    logic             byte_done_q;
    logic [7:0]       type_r;
    logic [7:0]       len_r;
    logic [7:0]       csum;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] idle_cnt;
    logic [7:0]       out_type_r;
    logic             pkt_err_r;
    logic [7:0]       drop_cnt;

    logic       new_byte;
    logic       in_packet;
    logic       timeout;
    logic       draining;
    logic       last_beat;
    logic       handshake;
    logic       buf_we;
    logic [7:0] rdata;

    // The receiver's done flag is a level; only its rising edge is a byte.
    assign new_byte  = bus.byte_done && !byte_done_q;
    assign in_packet = (state == S_TYPE) || (state == S_LEN) ||
                       (state == S_PAYLOAD) || (state == S_CHECK);
    // Expiry outranks a byte arriving on the same edge.
    assign timeout   = in_packet && (idle_cnt == IDLE_LIMIT);
    assign draining  = (state == S_DRAIN);
    assign last_beat = draining && (8'(rd_ptr) == len_r - 8'd1);
    assign handshake = draining && bus.out_ready;
    assign buf_we    = (state == S_PAYLOAD) && new_byte && !timeout;

    bt_pkt_buffer #(
        .DEPTH (MAX_LEN),
        .AW    (PTR_W)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_ptr),
        .wdata (bus.byte_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Stream outputs decode straight from state so reset drops them asynchronously.
    assign bus.out_valid  = draining;
    assign bus.out_data   = draining ? rdata : 8'h00;
    assign bus.out_last   = last_beat;
    assign bus.out_type   = out_type_r;
    assign bus.pkt_err    = pkt_err_r;
    assign bus.drop_count = drop_cnt;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state       <= S_HUNT;
            byte_done_q <= 1'b0;
            type_r      <= 8'h00;
            len_r       <= 8'h00;
            csum        <= 8'h00;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            idle_cnt    <= '0;
            out_type_r  <= 8'h00;
            pkt_err_r   <= 1'b0;
            drop_cnt    <= 8'h00;
        end else begin
            byte_done_q <= bus.byte_done;
            pkt_err_r   <= 1'b0;

            if (draining && new_byte && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            if (timeout) begin
                pkt_err_r <= 1'b1;
                idle_cnt  <= '0;
                state     <= S_HUNT;
            end else begin
                if (in_packet) begin
                    idle_cnt <= new_byte ? '0 : idle_cnt + CNT_W'(1);
                end

                case (state)
                    S_HUNT: begin
                        if (new_byte && (bus.byte_in == SYNC_BYTE)) begin
                            csum     <= 8'h00;
                            idle_cnt <= '0;
                            state    <= S_TYPE;
                        end
                    end
                    S_TYPE: begin
                        if (new_byte) begin
                            type_r <= bus.byte_in;
                            csum   <= bus.byte_in;
                            state  <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (new_byte) begin
                            if ((bus.byte_in == 8'h00) || (bus.byte_in > MAX_LEN8)) begin
                                pkt_err_r <= 1'b1;
                                state     <= S_HUNT;
                            end else begin
                                len_r  <= bus.byte_in;
                                csum   <= pkt_xor(type_r, bus.byte_in);
                                wr_ptr <= '0;
                                state  <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (new_byte) begin
                            csum   <= csum ^ bus.byte_in;
                            wr_ptr <= wr_ptr + PTR_W'(1);
                            if (8'(wr_ptr) == len_r - 8'd1) begin
                                state <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (new_byte) begin
                            if (bus.byte_in == csum) begin
                                rd_ptr     <= '0;
                                out_type_r <= type_r;
                                state      <= S_DRAIN;
                            end else begin
                                pkt_err_r <= 1'b1;
                                state     <= S_HUNT;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (handshake) begin
                            if (last_beat) begin
                                state <= S_HUNT;
                            end else begin
                                rd_ptr <= rd_ptr + PTR_W'(1);
                            end
                        end
                    end
                    default: state <= S_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bt_packet_deframer.sv
module tb_bt_packet_deframer;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int MAXL = 16;
    localparam int TO   = 60;

    logic clk = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk = ~clk;

    bt_packet_deframer_if bus ();

    bt_packet_deframer #(
        .SYNC_BYTE      (SYNC),
        .MAX_LEN        (MAXL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model (packet-level) ----------------
    logic [7:0] cur[$];        // bytes received since the sync marker
    logic [7:0] exp_q[$];      // payload beats still to be delivered
    logic [7:0] exp_type = 8'h00;
    bit         got_sync = 0;
    bit         exp_err  = 0;
    int         idle     = 0;
    int         drops    = 0;
    logic       prev_done = 1'b0;
    logic       m_nb;

    always @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            cur.delete(); exp_q.delete();
            exp_type = 8'h00; got_sync = 0; exp_err = 0;
            idle = 0; drops = 0; prev_done = 1'b0;
        end else begin
            m_nb = bus.byte_done && !prev_done;
            prev_done = bus.byte_done;
            exp_err = 0;
            if (exp_q.size() > 0) begin
                if (m_nb && drops < 255) drops++;
                if (bus.out_ready) void'(exp_q.pop_front());
            end else if (got_sync) begin
                if (idle == TO - 1) begin
                    exp_err = 1; got_sync = 0;
                end else if (m_nb) begin
                    idle = 0;
                    cur.push_back(bus.byte_in);
                    if (cur.size() == 2 && (cur[1] == 8'h00 || int'(cur[1]) > MAXL)) begin
                        exp_err = 1; got_sync = 0;
                    end else if (cur.size() >= 3 && cur.size() == int'(cur[1]) + 3) begin
                        logic [7:0] x;
                        x = 8'h00;
                        for (int i = 0; i < cur.size() - 1; i++) x ^= cur[i];
                        if (x == cur[cur.size()-1]) begin
                            for (int i = 2; i < cur.size() - 1; i++) exp_q.push_back(cur[i]);
                            exp_type = cur[0];
                        end else begin
                            exp_err = 1;
                        end
                        got_sync = 0;
                    end
                end else begin
                    idle++;
                end
            end else if (m_nb && bus.byte_in == SYNC) begin
                got_sync = 1; idle = 0; cur.delete();
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (rst_in) begin
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_err", bus.pkt_err, 0);
            chk("rst_drop", bus.drop_count, 0);
            chk("rst_type", bus.out_type, 0);
        end else begin
            chk("valid", bus.out_valid, exp_q.size() > 0);
            chk("pkt_err", bus.pkt_err, exp_err);
            chk("drop_count", bus.drop_count, drops);
            if (exp_q.size() > 0) begin
                chk("data", bus.out_data, exp_q[0]);
                chk("last", bus.out_last, exp_q.size() == 1);
                chk("type", bus.out_type, exp_type);
            end
        end
    end

    // ---------------- observer for hand-computed checks ----------------
    logic [7:0] obs_d[$];
    bit         obs_l[$];
    logic [7:0] obs_type;
    int         err_seen = 0;

    always @(negedge clk) begin
        if (!rst_in) begin
            if (bus.out_valid && bus.out_ready) begin
                obs_d.push_back(bus.out_data);
                obs_l.push_back(bus.out_last);
                obs_type = bus.out_type;
            end
            if (bus.pkt_err) err_seen++;
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_mode = 0;

    task automatic step();
        @(posedge clk);
        #2;
        if (rnd_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle_n(input int n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        bus.byte_in = b;
        bus.byte_done = 1'b1;
        repeat (hold) step();
        bus.byte_done = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_seq(input logic [7:0] s[$], input int hold, input int gap);
        foreach (s[i]) send_byte(s[i], hold, gap);
    endtask

    task automatic clear_obs();
        obs_d.delete(); obs_l.delete(); err_seen = 0;
    endtask

    logic [7:0] good[$] = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    logic [7:0] badc[$] = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};

    task automatic check_good(input string nm);
        chk({nm, "_beats"}, obs_d.size(), 2);
        if (obs_d.size() == 2) begin
            chk({nm, "_d0"}, obs_d[0], 8'h10);
            chk({nm, "_l0"}, obs_l[0], 0);
            chk({nm, "_d1"}, obs_d[1], 8'h20);
            chk({nm, "_l1"}, obs_l[1], 1);
        end
        chk({nm, "_type"}, obs_type, 8'h01);
        chk({nm, "_err"}, err_seen, 0);
    endtask

    initial begin
        logic [7:0] s[$];
        bus.byte_in = 8'h00;
        bus.byte_done = 1'b0;
        bus.out_ready = 1'b1;
        idle_n(3);
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_data", bus.out_data, 0);
        rst_in = 1'b0;
        idle_n(3);

        // good packet
        clear_obs();
        send_seq(good, 1, 1);
        idle_n(6);
        check_good("good");

        // held done level
        clear_obs();
        send_seq(good, 5, 1);
        idle_n(6);
        check_good("held");

        // bad checksum then good packet
        clear_obs();
        send_seq(badc, 1, 1);
        idle_n(4);
        chk("badcsum_err", err_seen, 1);
        chk("badcsum_beats", obs_d.size(), 0);
        clear_obs();
        send_seq(good, 2, 2);
        idle_n(6);
        check_good("after_bad");

        // length bounds
        clear_obs();
        s = '{8'hA5, 8'h07, 8'h00};
        send_seq(s, 1, 1);
        idle_n(3);
        chk("len0_err", err_seen, 1);
        s = '{8'hA5, 8'h07, 8'(MAXL + 1)};
        send_seq(s, 1, 1);
        idle_n(3);
        chk("len17_err", err_seen, 2);
        clear_obs();
        s = '{8'hA5, 8'h07, 8'h10};
        for (int i = 0; i < 16; i++) s.push_back(8'(i + 1));
        s.push_back(8'h07);   // 07 ^ 10 ^ (1^2^...^16)
        send_seq(s, 1, 1);
        idle_n(20);
        chk("len16_beats", obs_d.size(), 16);
        if (obs_d.size() == 16) begin
            chk("len16_first", obs_d[0], 8'h01);
            chk("len16_lastd", obs_d[15], 8'h10);
            chk("len16_lastf", obs_l[15], 1);
        end
        chk("len16_err", err_seen, 0);

        // backpressure and drops
        clear_obs();
        bus.out_ready = 1'b0;
        send_seq(good, 1, 1);
        s = '{8'h55, 8'hA5, 8'h77};
        send_seq(s, 1, 1);
        idle_n(2);
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_data", bus.out_data, 8'h10);
        chk("bp_drop", bus.drop_count, 3);
        chk("bp_nobeat", obs_d.size(), 0);
        bus.out_ready = 1'b1;
        idle_n(6);
        check_good("bp");

        // timeout
        clear_obs();
        s = '{8'hA5, 8'h01};
        send_seq(s, 1, 1);
        idle_n(TO - 5);
        chk("to_early", err_seen, 0);
        idle_n(10);
        chk("to_err", err_seen, 1);

        // reset in the middle of a drain
        bus.out_ready = 1'b0;
        send_seq(good, 1, 1);
        idle_n(3);
        chk("pre_rst_valid", bus.out_valid, 1);
        rst_in = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_drop", bus.drop_count, 0);
        idle_n(2);
        rst_in = 1'b0;
        bus.out_ready = 1'b1;
        idle_n(3);

        // randomized traffic checked by the model
        rnd_mode = 1;
        for (int p = 0; p < 150; p++) begin
            int kind, len, hold, gap, njunk;
            logic [7:0] typ, x, b;
            kind  = $urandom_range(0, 9);
            hold  = $urandom_range(1, 4);
            gap   = $urandom_range(1, 3);
            njunk = $urandom_range(0, 2);
            s.delete();
            for (int j = 0; j < njunk; j++) begin
                b = 8'($urandom_range(0, 255));
                s.push_back(b == SYNC ? 8'h00 : b);
            end
            typ = 8'($urandom_range(0, 255));
            len = (kind == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXL + 1, 255))
                              : $urandom_range(1, MAXL);
            s.push_back(SYNC);
            s.push_back(typ);
            s.push_back(8'(len));
            x = typ ^ 8'(len);
            if (kind != 0) begin
                for (int j = 0; j < len; j++) begin
                    b = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom_range(0, 255));
                    s.push_back(b);
                    x ^= b;
                end
                if (kind == 1) x ^= 8'(1 << $urandom_range(0, 7));
                if (kind != 2) s.push_back(x);
                else void'(s.pop_back());
            end
            send_seq(s, hold, gap);
            if (kind == 2) idle_n(TO + 3);
            idle_n($urandom_range(0, 20));
        end
        rnd_mode = 0;
        bus.out_ready = 1'b1;
        idle_n(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
